// File: rtl/neo_sdram_wb_arbiter.sv
// Two-port to single Wishbone master arbiter for the NeoGeo SDRAM path.
// Port B (sprite fetch) has priority, with a bounded run so port A is never starved.
module neo_sdram_wb_arbiter #(
  parameter int unsigned AW        = 25,
  parameter int unsigned DW        = 16,
  parameter int unsigned MAX_B_RUN = 4,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata,
  output logic [31:0]   wb_adr_o,
  output logic [31:0]   wb_dat_o,
  input  logic [31:0]   wb_dat_i,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic          wb_stb_o,
  output logic          wb_cyc_o,
  input  logic          wb_ack_i,
  output logic          busy,
  output logic          timeout_err
);

  localparam int unsigned BRW = $clog2(MAX_B_RUN + 1);
  localparam int unsigned WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_start;
  logic            w_grant_b;
  logic            w_bus_ack;
  logic            w_bus_to;
  logic [DW-1:0]   w_rd_val;

  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic            r_we;
  logic            r_grant_b;
  logic [BRW-1:0]  r_b_run;
  logic [WDW-1:0]  r_wd;
  logic            r_to_err;
  logic [DW-1:0]   r_a_rdata;
  logic [DW-1:0]   r_b_rdata;

  logic            w_unused_dat;
  assign w_unused_dat = ^wb_dat_i[31:DW];

  always_ff @(posedge clk_sys) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_grant_b   = 1'b0;
    w_bus_ack   = 1'b0;
    w_bus_to    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (a_req || b_req) begin
          w_start     = 1'b1;
          // B wins a tie unless it has already used its full run
          w_grant_b   = b_req && !(a_req && (r_b_run == BRW'(MAX_B_RUN)));
          w_state_nxt = S_BUS;
        end
      end
      S_BUS: begin
        if (wb_ack_i) begin
          w_bus_ack   = 1'b1;
          w_state_nxt = S_DONE;
        end else if (r_wd == WDW'(TIMEOUT - 1)) begin
          w_bus_to    = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    w_rd_val = w_bus_to ? '1 : wb_dat_i[DW-1:0];
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_we      <= 1'b0;
      r_grant_b <= 1'b0;
      r_b_run   <= '0;
      r_wd      <= '0;
      r_to_err  <= 1'b0;
      r_a_rdata <= '0;
      r_b_rdata <= '0;
    end else begin
      if (w_start) begin
        r_addr    <= w_grant_b ? b_addr  : a_addr;
        r_wdata   <= w_grant_b ? b_wdata : a_wdata;
        r_we      <= w_grant_b ? b_we    : a_we;
        r_grant_b <= w_grant_b;
        r_wd      <= '0;
        if (!w_grant_b)                           r_b_run <= '0;
        else if (r_b_run != BRW'(MAX_B_RUN))      r_b_run <= r_b_run + 1'b1;
      end
      if (r_state == S_BUS) r_wd <= r_wd + 1'b1;
      if ((w_bus_ack || w_bus_to) && !r_we) begin
        if (r_grant_b) r_b_rdata <= w_rd_val;
        else           r_a_rdata <= w_rd_val;
      end
      if (w_bus_to) r_to_err <= 1'b1;
    end
  end

  assign wb_adr_o    = {{(32-AW){1'b0}}, r_addr};
  assign wb_dat_o    = {{(32-DW){1'b0}}, r_wdata};
  assign wb_sel_o    = 4'hF;
  assign wb_we_o     = r_we;
  assign wb_stb_o    = (r_state == S_BUS);
  assign wb_cyc_o    = (r_state == S_BUS);
  assign busy        = (r_state != S_IDLE);
  assign a_ack       = (r_state == S_DONE) && !r_grant_b;
  assign b_ack       = (r_state == S_DONE) &&  r_grant_b;
  assign a_rdata     = r_a_rdata;
  assign b_rdata     = r_b_rdata;
  assign timeout_err = r_to_err;

endmodule

// File: tb/tb_neo_sdram_wb_arbiter.sv
// Directed bench for neo_sdram_wb_arbiter with MAX_B_RUN=2, TIMEOUT=8.
module tb_neo_sdram_wb_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [24:0] a_addr = '0, b_addr = '0;
  logic [15:0] a_wdata = '0, b_wdata = '0;
  logic        a_ack, b_ack, wb_we_o, wb_stb_o, wb_cyc_o, busy, timeout_err;
  logic [15:0] a_rdata, b_rdata;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [31:0] wb_dat_i = '0;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  int          slv_wait  = 0;
  int          slv_cnt   = 0;
  bit          slv_never = 1'b0;
  logic [31:0] slv_data  = '0;

  neo_sdram_wb_arbiter #(.AW(25), .DW(16), .MAX_B_RUN(2), .TIMEOUT(8)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o),
    .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk_sys = ~clk_sys;

  // Slave: acks in BUS cycle number slv_wait (0-based) unless slv_never
  initial begin
    forever begin
      @(posedge clk_sys); #1;
      if (wb_stb_o && !slv_never) begin
        wb_ack_i = (slv_cnt == slv_wait);
        wb_dat_i = slv_data;
        slv_cnt++;
      end else begin
        wb_ack_i = 1'b0;
        slv_cnt  = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_sys); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; a_req = 1'b0; b_req = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  // who: 0=A, 1=B, 2=both acks together, -1=no ack within bound
  task automatic wait_ack(output int lat, output int who);
    lat = -1; who = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (a_ack || b_ack) begin
        lat = i;
        who = (a_ack && b_ack) ? 2 : (b_ack ? 1 : 0);
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); tick();
    vectors++; if ({wb_stb_o, wb_cyc_o, busy, a_ack, b_ack, timeout_err, wb_we_o} !== 7'b0) begin miscompares++; $display("FAIL rst_ctrl got=%b exp=0000000", {wb_stb_o, wb_cyc_o, busy, a_ack, b_ack, timeout_err, wb_we_o}); end
    vectors++; if ({a_rdata, b_rdata} !== 32'h0) begin miscompares++; $display("FAIL rst_rdata got=%h exp=00000000", {a_rdata, b_rdata}); end
    vectors++; if ({wb_adr_o, wb_dat_o} !== 64'h0) begin miscompares++; $display("FAIL rst_bus got=%h exp=0", {wb_adr_o, wb_dat_o}); end
    vectors++; if (wb_sel_o !== 4'hF) begin miscompares++; $display("FAIL rst_sel got=%h exp=f", wb_sel_o); end
    reset = 1'b0;
  endtask

  task automatic test_a_read();
    int lat, who;
    do_reset();
    slv_never = 1'b0; slv_wait = 2; slv_data = 32'h0000_BEEF;
    a_we = 1'b0; a_addr = 25'h000100; a_req = 1'b1;
    tick();
    vectors++; if ({wb_stb_o, wb_cyc_o, busy} !== 3'b111) begin miscompares++; $display("FAIL a_rd_stb got=%b exp=111", {wb_stb_o, wb_cyc_o, busy}); end
    vectors++; if (wb_adr_o !== 32'h0000_0100) begin miscompares++; $display("FAIL a_rd_adr got=%h exp=00000100", wb_adr_o); end
    vectors++; if (wb_we_o !== 1'b0) begin miscompares++; $display("FAIL a_rd_we got=%b exp=0", wb_we_o); end
    wait_ack(lat, who);
    vectors++; if (lat !== 3 || who !== 0) begin miscompares++; $display("FAIL a_rd_ack lat=%0d who=%0d exp lat=3 who=0", lat, who); end
    vectors++; if (a_rdata !== 16'hBEEF) begin miscompares++; $display("FAIL a_rd_data got=%h exp=beef", a_rdata); end
    tick(); a_req = 1'b0;
    vectors++; if ({a_ack, busy} !== 2'b00) begin miscompares++; $display("FAIL a_rd_single got=%b exp=00", {a_ack, busy}); end
    tick(); tick();
    vectors++; if ({a_ack, busy, a_rdata} !== {2'b00, 16'hBEEF}) begin miscompares++; $display("FAIL a_rd_hold got=%h exp=0beef", {a_ack, busy, a_rdata}); end
  endtask

  task automatic test_b_write();
    int lat, who;
    do_reset();
    slv_never = 1'b0; slv_wait = 0; slv_data = 32'h0000_7777;
    b_we = 1'b1; b_addr = 25'h1FFFFFF; b_wdata = 16'h1234; b_req = 1'b1;
    tick();
    vectors++; if (wb_adr_o !== 32'h01FF_FFFF) begin miscompares++; $display("FAIL b_wr_adr got=%h exp=01ffffff", wb_adr_o); end
    vectors++; if ({wb_dat_o, wb_we_o, wb_stb_o} !== {32'h0000_1234, 2'b11}) begin miscompares++; $display("FAIL b_wr_bus dat=%h we=%b stb=%b exp 00001234 1 1", wb_dat_o, wb_we_o, wb_stb_o); end
    wait_ack(lat, who);
    vectors++; if (lat !== 1 || who !== 1) begin miscompares++; $display("FAIL b_wr_ack lat=%0d who=%0d exp lat=1 who=1", lat, who); end
    vectors++; if (b_rdata !== 16'h0000) begin miscompares++; $display("FAIL b_wr_rdata got=%h exp=0000", b_rdata); end
    tick(); b_req = 1'b0; b_we = 1'b0;
    tick();
    vectors++; if ({b_ack, busy, timeout_err} !== 3'b000) begin miscompares++; $display("FAIL b_wr_idle got=%b exp=000", {b_ack, busy, timeout_err}); end
  endtask

  task automatic test_arbitration();
    int lat, who;
    int exp_who [9] = '{1, 1, 0, 1, 1, 0, 0, 0, 0};
    do_reset();
    slv_never = 1'b0; slv_wait = 0; slv_data = 32'h0000_0001;
    a_we = 1'b0; b_we = 1'b0; a_addr = 25'h0AAAA; b_addr = 25'h0BBBB;
    a_req = 1'b1; b_req = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (k == 6) begin tick(); b_req = 1'b0; end
      wait_ack(lat, who);
      vectors++; if (who !== exp_who[k] || lat !== ((k == 0 || k == 6) ? 2 : 3)) begin miscompares++; $display("FAIL arb_%0d who=%0d lat=%0d exp who=%0d lat=%0d", k, who, lat, exp_who[k], (k == 0 || k == 6) ? 2 : 3); end
    end
    tick(); a_req = 1'b0;
  endtask

  task automatic test_timeout();
    int n, lat, who;
    do_reset();
    slv_never = 1'b1;
    a_we = 1'b0; a_addr = 25'h55; a_req = 1'b1;
    tick();
    n = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!wb_stb_o) break;
      n++;
    end
    vectors++; if (n !== 8) begin miscompares++; $display("FAIL to_stb_cycles got=%0d exp=8", n); end
    vectors++; if ({a_ack, b_ack, timeout_err} !== 3'b101) begin miscompares++; $display("FAIL to_ack got=%b exp=101", {a_ack, b_ack, timeout_err}); end
    vectors++; if (a_rdata !== 16'hFFFF) begin miscompares++; $display("FAIL to_rdata got=%h exp=ffff", a_rdata); end
    tick(); a_req = 1'b0;
    tick(); tick(); tick();
    vectors++; if ({a_ack, busy, timeout_err} !== 3'b001) begin miscompares++; $display("FAIL to_sticky got=%b exp=001", {a_ack, busy, timeout_err}); end
    slv_never = 1'b0; slv_wait = 1; slv_data = 32'hABCD_5A5A;
    b_we = 1'b0; b_addr = 25'h77; b_req = 1'b1;
    wait_ack(lat, who);
    vectors++; if (who !== 1 || lat !== 3) begin miscompares++; $display("FAIL to_next who=%0d lat=%0d exp who=1 lat=3", who, lat); end
    vectors++; if ({b_rdata, timeout_err} !== {16'h5A5A, 1'b1}) begin miscompares++; $display("FAIL to_next_data got=%h exp=b4b5", {b_rdata, timeout_err}); end
    tick(); b_req = 1'b0;
  endtask

  task automatic test_reset_midbus();
    int lat, who;
    do_reset();
    slv_never = 1'b1;
    a_we = 1'b0; b_we = 1'b0; a_addr = 25'h0AAAA; b_addr = 25'h0BBBB;
    a_req = 1'b1; b_req = 1'b1;
    wait_ack(lat, who);
    vectors++; if (who !== 1 || timeout_err !== 1'b1 || b_rdata !== 16'hFFFF) begin miscompares++; $display("FAIL rm_pre who=%0d err=%b rdata=%h exp 1 1 ffff", who, timeout_err, b_rdata); end
    tick(); tick();
    vectors++; if (wb_stb_o !== 1'b1 || wb_adr_o !== 32'h0000_BBBB) begin miscompares++; $display("FAIL rm_second_b stb=%b adr=%h exp 1 0000bbbb", wb_stb_o, wb_adr_o); end
    tick();
    reset = 1'b1;
    tick();
    vectors++; if ({wb_stb_o, wb_cyc_o, busy, a_ack, b_ack, timeout_err} !== 6'b0) begin miscompares++; $display("FAIL rm_ctrl got=%b exp=000000", {wb_stb_o, wb_cyc_o, busy, a_ack, b_ack, timeout_err}); end
    vectors++; if (b_rdata !== 16'h0000) begin miscompares++; $display("FAIL rm_rdata got=%h exp=0000", b_rdata); end
    slv_never = 1'b0; slv_wait = 0;
    tick();
    vectors++; if ({a_ack, b_ack} !== 2'b00) begin miscompares++; $display("FAIL rm_noack got=%b exp=00", {a_ack, b_ack}); end
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_ack(lat, who);
      vectors++; if (who !== ((k == 2) ? 0 : 1)) begin miscompares++; $display("FAIL rm_brun_%0d who=%0d exp=%0d", k, who, (k == 2) ? 0 : 1); end
    end
    tick(); a_req = 1'b0; b_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    int lat, who, n;
    do_reset();
    slv_never = 1'b0; slv_wait = 0;
    a_we = 1'b1; a_addr = 25'h200; a_wdata = 16'hCAFE; a_req = 1'b1;
    wait_ack(lat, who);
    vectors++; if (lat !== 2 || who !== 0) begin miscompares++; $display("FAIL b2b_first lat=%0d who=%0d exp lat=2 who=0", lat, who); end
    tick();
    tick();
    a_req = 1'b0;
    vectors++; if (wb_stb_o !== 1'b1 || wb_dat_o !== 32'h0000_CAFE) begin miscompares++; $display("FAIL b2b_second stb=%b dat=%h exp 1 0000cafe", wb_stb_o, wb_dat_o); end
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (a_ack) n++;
    end
    vectors++; if (n !== 1) begin miscompares++; $display("FAIL b2b_ack_count got=%0d exp=1", n); end
    vectors++; if ({busy, a_rdata} !== 17'h0) begin miscompares++; $display("FAIL b2b_end got=%h exp=0", {busy, a_rdata}); end
    a_we = 1'b0;
  endtask

  initial begin
    test_reset();
    test_a_read();
    test_b_write();
    test_arbitration();
    test_timeout();
    test_reset_midbus();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
